uart_fifo_ctrl: RTL
===================

// Module: uart_fifo_ctrl
// PURPOSE
//   Parametrised synchronous FIFO for the UART TX/RX datapaths. It replaces the single-mode buffer.
//   Adds an optional first-word-fall-through (FWFT) read mode, a fill-level output and an almost-empty flag.
//   Adds sticky overflow/underflow error flags, a synchronous flush and a single-owner occupancy counter.
//   Sits between uart_rx/uart_tx and the case-converter core, one instance per direction.
// PARAMETERS
//   WIDTH      8   data word width, bits (>=1)
//   DEPTH      16  entries; power of two, >=2
//   AFULL_TH   12  o_almostfull asserted when level >= AFULL_TH (1..DEPTH)
//   AEMPTY_TH  2   o_almostempty asserted when level <= AEMPTY_TH (0..DEPTH-1)
//   FWFT       0   0 = registered read (1-cycle latency); 1 = head word presented without i_rd_en
// PORTS
//   i_clk          in   1              single clock, rising edge
//   i_rst_n        in   1              reset, asynchronous, active-low
//   i_wr_en        in   1              write request
//   i_wr_data      in   WIDTH          write data
//   i_rd_en        in   1              read request (FWFT=1: pop/acknowledge of head)
//   o_rd_data      out  WIDTH          read data
//   o_rd_valid     out  1              o_rd_data valid (see BEHAVIOUR)
//   i_flush        in   1              synchronous discard of all contents
//   i_clr_err      in   1              clears o_overflow/o_underflow
//   o_empty        out  1              level == 0
//   o_full         out  1              level == DEPTH
//   o_almostfull   out  1              level >= AFULL_TH
//   o_almostempty  out  1              level <= AEMPTY_TH
//   o_level        out  $clog2(DEPTH)+1  current occupancy 0..DEPTH
//   o_overflow     out  1              sticky: write attempted while full
//   o_underflow    out  1              sticky: read attempted while empty
// BEHAVIOUR
//   Reset (i_rst_n=0, immediate): ptrs=0, level=0, o_rd_valid=0, o_rd_data=0, o_overflow=o_underflow=0.
//     Consequently o_empty=1, o_almostempty=1, o_full=0, o_almostfull=0. Memory array is not reset.
//   Pointers are ADDR_W=$clog2(DEPTH) bits and wrap naturally DEPTH-1 -> 0. Level is ADDR_W+1 bits.
//   Level is updated in exactly one always block.
//   Write accepted iff i_wr_en && !o_full: mem[wr_ptr]<=i_wr_data, wr_ptr++.
//   Read accepted iff i_rd_en && !o_empty: rd_ptr++.
//   Level update: +1 on write-only, -1 on read-only, unchanged on both or neither.
//   Full + rd + wr same cycle: read accepted, write dropped (flag status taken pre-edge); level -> DEPTH-1, o_overflow set.
//   Empty + rd + wr same cycle (either mode): write accepted, read dropped; level -> 1, o_underflow set.
//   o_overflow set on i_wr_en && o_full; o_underflow set on i_rd_en && o_empty. Both hold until i_clr_err.
//   Set has priority over clear in the same cycle.
//   FWFT=0: on accepted read, o_rd_data<=mem[rd_ptr] and o_rd_valid=1 for exactly the next cycle.
//     o_rd_data holds its last value otherwise. Back-to-back reads give one word per cycle.
//   FWFT=1: o_rd_valid = !o_empty and o_rd_data = mem[rd_ptr] (combinational from array).
//     A word written at edge N is visible after edge N. i_rd_en pops the head.
//   i_flush=1: ptrs=0, level=0, o_rd_valid=0 next cycle. Concurrent rd/wr are ignored and flags do not set.
//     Sticky flags are otherwise preserved.
//   All status outputs are combinational from level (no extra latency).
// STRUCTURE
//   Package uart_fifo_pkg: ADDR_W/level-width helper function and default WIDTH/DEPTH constants.
//   Sub-module uart_fifo_ram: simple dual-port array with sync write and async read.
//   This module owns pointers, level, flags and mode muxing.
// TESTING (WIDTH=8, DEPTH=16, AFULL_TH=12, AEMPTY_TH=2 unless stated)
//   1 FWFT=0: write A1,A2,A3,A4 then 4 reads -> o_rd_valid 1 cycle after each rd with A1..A4 in order;
//     o_level 4->0; o_almostempty goes 0 at level 3.
//   2 Fill 16 words -> o_almostfull at level 12, o_full at 16; 17th write dropped, o_overflow=1;
//     i_clr_err -> 0; contents unchanged.
//   3 Level 5, rd+wr together -> level stays 5. At full, rd+wr -> level 15, o_overflow=1, order intact.
//     At empty, rd+wr -> level 1, o_underflow=1, written word is next read.
//   4 Interleave 40 writes (0x00..0x27) and reads across pointer wrap -> reads return 0x00..0x27 exactly.
//   5 FWFT=1: write 5C into empty FIFO -> next cycle o_rd_valid=1, o_rd_data=5C with i_rd_en=0.
//     Write 5D, pulse i_rd_en -> o_rd_data=5D.
//   6 Level 7, i_flush with i_wr_en=1 -> level 0, o_empty=1, no write. Later drop i_rst_n mid-write
//     -> all outputs reach reset values before next edge.

Source files
------------

// File: rtl/uart_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_fifo_pkg
//   Shared constants and width helpers for the UART FIFO controller slice.
//   Contents:
//     DEF_WIDTH / DEF_DEPTH  default data width and entry count
//     addr_w(depth)          pointer width for a power-of-two depth
//     lvl_w(depth)           occupancy width (one extra bit so DEPTH fits)
// ---------------------------------------------------------------------------
package uart_fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    // Pointer width. DEPTH is a power of two, so pointers wrap naturally
    // from DEPTH-1 back to 0 without any compare logic.
    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Occupancy needs to represent 0..DEPTH inclusive.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : uart_fifo_pkg

// File: rtl/uart_fifo_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_fifo_ctrl_if
//   Bundles the write side, read side, control and status signals of one
//   uart_fifo_ctrl instance.
//   Modports:
//     master  the client (uart_rx/uart_tx side and the consumer)
//     slave   the FIFO itself
//   Signals:
//     i_wr_en, i_wr_data        write request and data
//     i_rd_en                   read request (FWFT: pop of the head word)
//     o_rd_data, o_rd_valid     read data and its qualifier
//     i_flush, i_clr_err        synchronous discard / sticky-error clear
//     o_empty, o_full, o_almostfull, o_almostempty, o_level
//     o_overflow, o_underflow   sticky error flags
//
//   Handshake semantics: a write transfers on a rising edge where i_wr_en=1
//   and o_full=0 (o_full acts as the inverted ready); a read transfers on a
//   rising edge where i_rd_en=1 and o_empty=0. Requests made against the
//   wrong flag are dropped and recorded in the sticky error flags. Neither
//   side is required to hold its request until accepted.
// ---------------------------------------------------------------------------
interface uart_fifo_ctrl_if
    import uart_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int LVL_W = lvl_w(DEPTH);

    logic             i_wr_en;
    logic [WIDTH-1:0] i_wr_data;
    logic             i_rd_en;
    logic [WIDTH-1:0] o_rd_data;
    logic             o_rd_valid;
    logic             i_flush;
    logic             i_clr_err;
    logic             o_empty;
    logic             o_full;
    logic             o_almostfull;
    logic             o_almostempty;
    logic [LVL_W-1:0] o_level;
    logic             o_overflow;
    logic             o_underflow;

    modport master (
        output i_wr_en, i_wr_data, i_rd_en, i_flush, i_clr_err,
        input  o_rd_data, o_rd_valid, o_empty, o_full, o_almostfull,
               o_almostempty, o_level, o_overflow, o_underflow
    );

    modport slave (
        input  i_wr_en, i_wr_data, i_rd_en, i_flush, i_clr_err,
        output o_rd_data, o_rd_valid, o_empty, o_full, o_almostfull,
               o_almostempty, o_level, o_overflow, o_underflow
    );

endinterface : uart_fifo_ctrl_if

// File: rtl/uart_fifo_ram.sv
// ---------------------------------------------------------------------------
// uart_fifo_ram
//   Simple dual-port storage array: synchronous write, asynchronous read.
//   The array is intentionally not reset; occupancy tracking in the owner
//   guarantees no unwritten location is ever presented as valid.
//   Ports:
//     i_clk      write clock, rising edge
//     i_wr_en    write strobe
//     i_wr_addr  write address
//     i_wr_data  write data
//     i_rd_addr  read address
//     o_rd_data  read data (combinational from the array)
// ---------------------------------------------------------------------------
module uart_fifo_ram
    import uart_fifo_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = addr_w(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule : uart_fifo_ram

// File: rtl/uart_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// uart_fifo_ctrl
//   Parametrised synchronous FIFO for the UART TX/RX datapaths, one instance
//   per direction. Owns the read/write pointers, the single occupancy
//   counter, the sticky error flags and the read-mode muxing; storage lives
//   in uart_fifo_ram.
//   Parameters:
//     WIDTH      data word width
//     DEPTH      entries, power of two >= 2
//     AFULL_TH   o_almostfull when level >= AFULL_TH
//     AEMPTY_TH  o_almostempty when level <= AEMPTY_TH
//     FWFT       0: registered read, data one cycle after an accepted read
//                1: head word presented continuously, i_rd_en pops it
//   Ports:
//     i_clk      clock, rising edge
//     i_rst_n    asynchronous active-low reset
//     bus        uart_fifo_ctrl_if slave modport (data, control, status)
// ---------------------------------------------------------------------------
module uart_fifo_ctrl
    import uart_fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    uart_fifo_ctrl_if.slave bus
);

    localparam int ADDR_W = addr_w(DEPTH);
    localparam int LVL_W  = lvl_w(DEPTH);

    localparam logic [LVL_W-1:0] LVL_DEPTH  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AFULL  = LVL_W'(AFULL_TH);
    localparam logic [LVL_W-1:0] LVL_AEMPTY = LVL_W'(AEMPTY_TH);
    localparam logic [LVL_W-1:0] LVL_ONE    = LVL_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [LVL_W-1:0]  level;
    logic              empty;
    logic              full;
    logic              wr_acc;
    logic              rd_acc;
    logic              overflow_q;
    logic              underflow_q;
    logic [WIDTH-1:0]  ram_rdata;

    assign empty = (level == '0);
    assign full  = (level == LVL_DEPTH);

    // Acceptance uses the pre-edge flags. When full, a concurrent read
    // still goes through while the write is dropped; when empty, the write
    // goes through and the read is dropped. A flush overrides both.
    assign wr_acc = bus.i_wr_en && !full  && !bus.i_flush;
    assign rd_acc = bus.i_rd_en && !empty && !bus.i_flush;

    // -----------------------------------------------------------------------
    // Pointers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Occupancy: the only place level is written.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            level <= '0;
        end else if (bus.i_flush) begin
            level <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Sticky error flags. A fresh violation wins over a same-cycle clear so
    // that no event is lost. Requests during a flush are ignored and do not
    // count as violations.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (!bus.i_flush && bus.i_wr_en && full) begin
                overflow_q <= 1'b1;
            end else if (bus.i_clr_err) begin
                overflow_q <= 1'b0;
            end

            if (!bus.i_flush && bus.i_rd_en && empty) begin
                underflow_q <= 1'b1;
            end else if (bus.i_clr_err) begin
                underflow_q <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    uart_fifo_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (wr_acc),
        .i_wr_addr (wr_ptr),
        .i_wr_data (bus.i_wr_data),
        .i_rd_addr (rd_ptr),
        .o_rd_data (ram_rdata)
    );

    // -----------------------------------------------------------------------
    // Read-mode muxing
    // -----------------------------------------------------------------------
    if (FWFT != 0) begin : g_fwft
        // Head word straight from the array. While empty the data is forced
        // to zero so the unreset array never leaks onto the output, which
        // also gives the all-zero read data expected out of reset.
        assign bus.o_rd_valid = !empty;
        assign bus.o_rd_data  = empty ? '0 : ram_rdata;
    end else begin : g_registered
        logic [WIDTH-1:0] rd_data_q;
        logic             rd_valid_q;

        // Valid is a one-cycle pulse per accepted read; data holds its last
        // value between reads. A flush forces rd_acc low, which clears valid.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    rd_data_q <= ram_rdata;
                end
            end
        end

        assign bus.o_rd_valid = rd_valid_q;
        assign bus.o_rd_data  = rd_data_q;
    end

    // -----------------------------------------------------------------------
    // Status: combinational from level, no added latency.
    // -----------------------------------------------------------------------
    assign bus.o_empty       = empty;
    assign bus.o_full        = full;
    assign bus.o_almostfull  = (level >= LVL_AFULL);
    assign bus.o_almostempty = (level <= LVL_AEMPTY);
    assign bus.o_level       = level;
    assign bus.o_overflow    = overflow_q;
    assign bus.o_underflow   = underflow_q;

endmodule : uart_fifo_ctrl
